alu_sequencer: RTL and testbench

- Multi-cycle issue/capture controller that drives the ALU's A/B/op inputs and collects its combinational result.
- Mirrors the Y-in / Z-out register discipline of the datapath:
  - accepts one operation request over a valid/ready handshake;
  - stages operand A through a Y register and presents B and op for one execute cycle;
  - latches the result and flags into a Z register;
  - holds the response until the consumer takes it.
- Sits between the control/decoder logic and the ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_reg.sv | 12 +
 rtl/alu_sequencer.sv | 61 ++++++
 tb/tb_alu_sequencer.sv | 135 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode map and sequencer state encoding
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam int ALU_OPW = 4;
  localparam logic [3:0] OP_OR = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  typedef enum logic [1:0] {IDLE, LOAD_Y, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshake plus ALU drive/capture signals
interface alu_sequencer_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH, parameter int OPW = alu_pkg::ALU_OPW);
  logic req_valid;
  logic req_ready;
  logic [OPW-1:0] req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0] alu_op;
  logic [WIDTH-1:0] alu_result;
  logic rsp_valid;
  logic rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_zero;
  logic rsp_neg;
  logic rsp_err;
  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_err
  );
  modport slave (
    input req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_err
  );
endinterface

// File: rtl/alu_reg.sv
// alu_reg: enabled register with asynchronous active-low clear, used for Y and Z
module alu_reg #(parameter int WIDTH = 8) (
  input logic clock,
  input logic clear,
  input logic en,
  input logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge clear)
    if (!clear) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU op through Y-in/Z-out registers and holds the response
module alu_sequencer import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW = ALU_OPW,
  parameter int MAX_OP = 12
) (
  input logic clock,
  input logic clear,
  alu_sequencer_if.slave bus
);
  state_t state, next;
  logic [OPW-1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, y, z, z_d;
  logic err, take, bad, y_en, z_en;
  assign take = state == IDLE && bus.req_valid;
  assign bad = 32'(bus.req_op) > 32'(MAX_OP);
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.req_valid ? (bad ? RESP : LOAD_Y) : IDLE;
      LOAD_Y: next = EXEC;
      EXEC: next = RESP;
      RESP: next = bus.rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    y_en = state == LOAD_Y;
    z_en = state == EXEC || (take && bad);
    z_d = state == EXEC ? bus.alu_result : '0;
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.alu_a = y;
    bus.alu_b = state == EXEC ? b_q : '0;
    bus.alu_op = state == EXEC ? op_q : '0;
    bus.rsp_data = z;
    bus.rsp_zero = z == '0;
    bus.rsp_neg = z[WIDTH-1];
    bus.rsp_err = err;
  end
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      err <= 1'b0;
    end else begin
      if (take) begin
        op_q <= bus.req_op;
        a_q <= bus.req_a;
        b_q <= bus.req_b;
      end
      if (take && bad) err <= 1'b1;
      else if (state == EXEC) err <= 1'b0;
    end
  alu_reg #(.WIDTH(WIDTH)) u_y (.clock(clock), .clear(clear), .en(y_en), .d(a_q), .q(y));
  alu_reg #(.WIDTH(WIDTH)) u_z (.clock(clock), .clear(clear), .en(z_en), .d(z_d), .q(z));
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed transactions against a behavioural ALU closing the loop
module tb_alu_sequencer;
  import alu_pkg::*;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_sequencer_if #(.WIDTH(8), .OPW(4)) bus ();
  alu_sequencer #(.WIDTH(8), .OPW(4), .MAX_OP(12)) dut (.clock(clock), .clear(clear), .bus(bus));
  always #5 clock = ~clock;
  always_comb begin
    bus.alu_result = 8'h00;
    case (bus.alu_op)
      OP_OR: bus.alu_result = bus.alu_a | bus.alu_b;
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_NOT: bus.alu_result = ~bus.alu_a;
      OP_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      OP_NEG: bus.alu_result = -bus.alu_a;
      OP_MUL: bus.alu_result = bus.alu_a * bus.alu_b;
      OP_DIV: bus.alu_result = bus.alu_b == 8'h00 ? 8'hFF : bus.alu_a / bus.alu_b;
      OP_SHL: bus.alu_result = bus.alu_a << bus.alu_b[2:0];
      OP_SHR: bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
      OP_SHRA: bus.alu_result = 8'($signed(bus.alu_a) >>> bus.alu_b[2:0]);
      OP_ROL: bus.alu_result = 8'({bus.alu_a, bus.alu_a} >> (4'd8 - {1'b0, bus.alu_b[2:0]}));
      OP_ROR: bus.alu_result = 8'({bus.alu_a, bus.alu_a} >> bus.alu_b[2:0]);
      default: bus.alu_result = 8'h00;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input bit illegal, input int hold);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_a = 8'hEE;
    bus.req_b = 8'hEE;
    bus.req_op = 4'd7;
    if (!illegal) begin
      chk("loady_ready", 32'(bus.req_ready), 0);
      chk("loady_valid", 32'(bus.rsp_valid), 0);
      @(negedge clock);
      chk("exec_alu_a", 32'(bus.alu_a), 32'(a));
      chk("exec_alu_b", 32'(bus.alu_b), 32'(b));
      chk("exec_alu_op", 32'(bus.alu_op), 32'(op));
      chk("exec_valid", 32'(bus.rsp_valid), 0);
      @(negedge clock);
    end else begin
      chk("illegal_alu_op", 32'(bus.alu_op), 0);
      chk("illegal_alu_b", 32'(bus.alu_b), 0);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_data", 32'(bus.rsp_data), 32'(exp));
      chk("hold_ready", 32'(bus.req_ready), 0);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_data", 32'(bus.rsp_data), 32'(exp));
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(exp == 8'h00));
    chk("rsp_neg", 32'(bus.rsp_neg), 32'(exp[7]));
    chk("rsp_err", 32'(bus.rsp_err), 32'(illegal));
    chk("rsp_alu_op", 32'(bus.alu_op), 0);
    @(negedge clock);
    chk("after_valid", 32'(bus.rsp_valid), 0);
    chk("after_data_kept", 32'(bus.rsp_data), 32'(exp));
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_rsp_zero"}, 32'(bus.rsp_zero), 1);
    chk({tag, "_rsp_neg"}, 32'(bus.rsp_neg), 0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 0);
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 4'd0;
    bus.req_a = 8'h00;
    bus.req_b = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    clear = 1'b1;
    @(negedge clock);
    chk_reset_vals("released");
    txn(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 0);
    txn(OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0, 0);
    txn(OP_SUB, 8'h10, 8'h03, 8'h0D, 1'b0, 0);
    txn(4'd13, 8'h55, 8'h00, 8'h00, 1'b1, 0);
    chk("illegal_y_kept", 32'(bus.alu_a), 32'h10);
    txn(4'd15, 8'hAA, 8'h11, 8'h00, 1'b1, 2);
    txn(OP_OR, 8'h0C, 8'h30, 8'h3C, 1'b0, 5);
    txn(OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 0);
    txn(OP_SUB, 8'h09, 8'h04, 8'h05, 1'b0, 0);
    txn(OP_ROL, 8'h81, 8'h01, 8'h03, 1'b0, 0);
    txn(OP_NEG, 8'h01, 8'h00, 8'hFF, 1'b0, 1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op = OP_ADD;
    bus.req_a = 8'h11;
    bus.req_b = 8'h22;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("pre_reset_exec_op", 32'(bus.alu_op), 32'(OP_ADD));
    #1 clear = 1'b0;
    #1 chk_reset_vals("midexec");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("midexec_no_rsp", 32'(bus.rsp_valid), 0);
    end
    clear = 1'b1;
    @(negedge clock);
    chk("post_reset_no_rsp", 32'(bus.rsp_valid), 0);
    txn(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
